// File: rtl/stage1_ctrl.sv
// Job sequencer for one stage1 conv instance: weight/BN load, vector streaming,
// drain and completion, with a fixed-latency valid/last tag pipe alongside the datapath.
module stage1_ctrl #(
    parameter int ARRAY_N  = 9,
    parameter int CNT_W    = 16,
    parameter int PIPE_LAT = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             abort,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             weight_en,
    output logic [CNT_W-1:0] load_idx,
    output logic             fm_en,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    num_vec_q, num_vec_d;
    logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
    logic [PIPE_LAT-1:0] vpipe_q, vpipe_d;
    logic [PIPE_LAT-1:0] lpipe_q, lpipe_d;
    logic                accept_s;
    logic                last_s;

    // State, counters and tag pipe registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            num_vec_q  <= '0;
            load_cnt_q <= '0;
            vec_cnt_q  <= '0;
            vpipe_q    <= '0;
            lpipe_q    <= '0;
        end else begin
            state_q    <= state_d;
            num_vec_q  <= num_vec_d;
            load_cnt_q <= load_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            vpipe_q    <= vpipe_d;
            lpipe_q    <= lpipe_d;
        end
    end

    // Next-state, counter and tag pipe logic
    always_comb begin
        state_d    = state_q;
        num_vec_d  = num_vec_q;
        load_cnt_d = load_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        accept_s   = (state_q == S_STREAM) && src_valid;
        last_s     = accept_s && (vec_cnt_q == (num_vec_q - {{(CNT_W-1){1'b0}}, 1'b1}));
        vpipe_d    = {vpipe_q[PIPE_LAT-2:0], accept_s};
        lpipe_d    = {lpipe_q[PIPE_LAT-2:0], last_s};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    num_vec_d  = num_vec;
                    load_cnt_d = '0;
                    vec_cnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (load_cnt_q == CNT_W'(ARRAY_N - 1)) begin
                    load_cnt_d = '0;
                    if (num_vec_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    load_cnt_d = load_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_STREAM: begin
                if (accept_s) begin
                    vec_cnt_d = vec_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            // Leave as soon as only the output stage still holds a tag, so done
            // lands the cycle after the final out_valid.
            S_DRAIN: begin
                if (vpipe_q[PIPE_LAT-2:0] == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            vpipe_d = '0;
            lpipe_d = '0;
        end else begin
            vpipe_d = vpipe_d;
        end
    end

    assign src_ready = (state_q == S_STREAM);
    assign fm_en     = accept_s;
    assign weight_en = (state_q == S_LOAD);
    assign load_idx  = (state_q == S_LOAD) ? load_cnt_q : '0;
    assign out_valid = vpipe_q[PIPE_LAT-1];
    assign out_last  = vpipe_q[PIPE_LAT-1] & lpipe_q[PIPE_LAT-1];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_stage1_ctrl.sv
// Directed bench for stage1_ctrl: per-job output traces compared against
// hand-derived cycle masks (offset 0 = cycle in which start is driven).
module tb_stage1_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num_vec;
    logic        abort;
    logic        src_valid;
    logic        src_ready;
    logic        weight_en;
    logic [15:0] load_idx;
    logic        fm_en;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;

    int total_s;
    int bad_s;

    logic [63:0] we_tr, li_tr, sr_tr, fm_tr, ov_tr, ol_tr, bz_tr, dn_tr;

    stage1_ctrl #(.ARRAY_N(9), .CNT_W(16), .PIPE_LAT(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_vec   (num_vec),
        .abort     (abort),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .weight_en (weight_en),
        .load_idx  (load_idx),
        .fm_en     (fm_en),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_s++;
        if (got !== exp) begin
            bad_s++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = 64'd0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Runs 64 cycles from a start; src_valid follows pat from stream offset 10.
    task automatic run_job(input logic [15:0] nv, input logic [15:0] pat,
                           input logic [63:0] start_m, input logic [63:0] abort_m);
        we_tr = 64'd0; li_tr = 64'd0; sr_tr = 64'd0; fm_tr = 64'd0;
        ov_tr = 64'd0; ol_tr = 64'd0; bz_tr = 64'd0; dn_tr = 64'd0;
        for (int o = 0; o < 64; o++) begin
            start     = start_m[o];
            num_vec   = (o == 0) ? nv : nv + 16'd4;
            abort     = abort_m[o];
            src_valid = (o >= 10 && o < 26) ? pat[o-10] : 1'b0;
            #1;
            we_tr[o] = weight_en;
            li_tr[o] = weight_en && (load_idx == 16'(o - 1));
            sr_tr[o] = src_ready;
            fm_tr[o] = fm_en;
            ov_tr[o] = out_valid;
            ol_tr[o] = out_last;
            bz_tr[o] = busy;
            dn_tr[o] = done;
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; src_valid = 1'b0; num_vec = 16'd0;
    endtask

    initial begin
        logic [63:0] acc_ov, acc_dn, acc_bz;
        clk = 1'b0; reset = 1'b1; start = 1'b0; num_vec = 16'd0;
        abort = 1'b0; src_valid = 1'b0;
        total_s = 0; bad_s = 0;

        @(posedge clk); @(posedge clk); #1;
        chk("reset_outs", {56'd0, busy, done, weight_en, src_ready, out_valid, out_last, fm_en, |load_idx}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // T1: four back-to-back vectors
        run_job(16'd4, 16'hFFFF, 64'd1, 64'd0);
        chk("t1_we",   we_tr, rng(1, 9));
        chk("t1_lidx", li_tr, rng(1, 9));
        chk("t1_rdy",  sr_tr, rng(10, 13));
        chk("t1_fm",   fm_tr, rng(10, 13));
        chk("t1_ov",   ov_tr, rng(30, 33));
        chk("t1_ol",   ol_tr, rng(33, 33));
        chk("t1_done", dn_tr, rng(34, 34));
        chk("t1_busy", bz_tr, rng(1, 34));

        // T2: bubbles 1,0,0,1,1,0,1,1
        run_job(16'd5, 16'b0000_0000_1101_1001, 64'd1, 64'd0);
        chk("t2_rdy",  sr_tr, rng(10, 17));
        chk("t2_fm",   fm_tr, rng(10, 10) | rng(13, 14) | rng(16, 17));
        chk("t2_ov",   ov_tr, rng(30, 30) | rng(33, 34) | rng(36, 37));
        chk("t2_ol",   ol_tr, rng(37, 37));
        chk("t2_done", dn_tr, rng(38, 38));

        // T3: empty job
        run_job(16'd0, 16'hFFFF, 64'd1, 64'd0);
        chk("t3_we",   we_tr, rng(1, 9));
        chk("t3_rdy",  sr_tr, 64'd0);
        chk("t3_ov",   ov_tr, 64'd0);
        chk("t3_done", dn_tr, rng(10, 10));
        chk("t3_busy", bz_tr, rng(1, 10));

        // T4: abort on the 2nd accept, then a normal job
        run_job(16'd6, 16'hFFFF, 64'd1, rng(11, 11));
        chk("t4_fm",   fm_tr, rng(10, 11));
        chk("t4_ov",   ov_tr, 64'd0);
        chk("t4_done", dn_tr, 64'd0);
        chk("t4_busy", bz_tr, rng(1, 11));
        run_job(16'd2, 16'hFFFF, 64'd1, 64'd0);
        chk("t4b_ov",   ov_tr, rng(30, 31));
        chk("t4b_ol",   ol_tr, rng(31, 31));
        chk("t4b_done", dn_tr, rng(32, 32));

        // T5: stray starts during LOAD and STREAM with a different num_vec
        run_job(16'd3, 16'hFFFF, rng(0, 0) | rng(3, 3) | rng(11, 11), 64'd0);
        chk("t5_we",   we_tr, rng(1, 9));
        chk("t5_fm",   fm_tr, rng(10, 12));
        chk("t5_ov",   ov_tr, rng(30, 32));
        chk("t5_ol",   ol_tr, rng(32, 32));
        chk("t5_done", dn_tr, rng(33, 33));

        // T6: async reset while draining one vector
        start = 1'b1; num_vec = 16'd1; src_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int o = 1; o < 15; o++) begin
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
        chk("t6_busy_pre", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_outs", {56'd0, busy, done, weight_en, src_ready, out_valid, out_last, fm_en, |load_idx}, 64'd0);
        #2 reset = 1'b0;
        acc_ov = 64'd0; acc_dn = 64'd0; acc_bz = 64'd0;
        for (int o = 0; o < 30; o++) begin
            @(posedge clk); #1;
            acc_ov[o] = out_valid;
            acc_dn[o] = done;
            acc_bz[o] = busy;
        end
        chk("t6_ov_after",   acc_ov, 64'd0);
        chk("t6_done_after", acc_dn, 64'd0);
        chk("t6_busy_after", acc_bz, 64'd0);

        $display("test done: total=%0d bad=%0d", total_s, bad_s);
        $finish;
    end

endmodule
